// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner
//
// Front end for the traffic-light controller. Cleans up the raw vehicle-loop
// and siren-detector signals so the controller only ever sees stable levels.
//
//   loop path  : 2-flop synchroniser -> debounce -> car_detected,
//                car_arrival pulse on each rise, saturating arrivals count.
//   siren path : 2-flop synchroniser -> emergency FSM
//                (IDLE -> CONFIRM -> ACTIVE <-> HOLD -> COOLDOWN -> IDLE).
//
// Ports
//   clk             system clock, rising edge
//   rst             asynchronous active-low reset
//   loop_raw        raw loop detector (asynchronous, may bounce)
//   siren_raw       raw siren detector (asynchronous, may glitch)
//   clear_arrivals  synchronous clear of the arrivals counter
//   car_detected    debounced vehicle presence
//   car_arrival     one-cycle pulse, high in the first cycle car_detected is 1
//   emergency       validated emergency override (1 in ACTIVE or HOLD)
//   arrivals        saturating count of car_arrival pulses
//   emg_state       emergency FSM state, exposed for debug
//
// All outputs are registered. The loop and siren paths never interact.

module traffic_sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int EMG_CONFIRM     = 3,
  parameter int EMG_HOLD        = 8,
  parameter int EMG_COOLDOWN    = 4,
  parameter int CNT_W           = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             loop_raw,
  input  logic             siren_raw,
  input  logic             clear_arrivals,
  output logic             car_detected,
  output logic             car_arrival,
  output logic             emergency,
  output logic [CNT_W-1:0] arrivals,
  output logic [2:0]       emg_state
);

  localparam int DB_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  localparam int EMG_MAX_A = (EMG_CONFIRM > EMG_HOLD) ? EMG_CONFIRM : EMG_HOLD;
  localparam int EMG_MAX   = (EMG_MAX_A > EMG_COOLDOWN) ? EMG_MAX_A : EMG_COOLDOWN;
  localparam int EC_W      = $clog2(EMG_MAX + 1);

  localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [EC_W-1:0] CONF_LAST = EC_W'(EMG_CONFIRM - 1);
  localparam logic [EC_W-1:0] HOLD_LAST = EC_W'(EMG_HOLD - 1);
  localparam logic [EC_W-1:0] COOL_LAST = EC_W'(EMG_COOLDOWN - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_CONFIRM  = 3'd1,
    S_ACTIVE   = 3'd2,
    S_HOLD     = 3'd3,
    S_COOLDOWN = 3'd4
  } emg_state_t;

  // --------------------------------------------------------------------------
  // Synchronisers
  // --------------------------------------------------------------------------
  logic loop_m, loop_s;
  logic siren_m, siren_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      loop_m  <= 1'b0;
      loop_s  <= 1'b0;
      siren_m <= 1'b0;
      siren_s <= 1'b0;
    end else begin
      loop_m  <= loop_raw;
      loop_s  <= loop_m;
      siren_m <= siren_raw;
      siren_s <= siren_m;
    end
  end

  // --------------------------------------------------------------------------
  // Loop debounce, arrival pulse and arrivals counter
  // --------------------------------------------------------------------------
  // db_cnt counts consecutive cycles in which loop_s disagrees with
  // car_detected; the flip happens on the cycle the count would reach
  // DEBOUNCE_CYCLES, so a clean raw step shows up 2+DEBOUNCE_CYCLES edges later.
  logic [DB_W-1:0] db_cnt;
  logic            db_flip;

  assign db_flip = (loop_s != car_detected) && (db_cnt == DB_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      db_cnt       <= '0;
      car_detected <= 1'b0;
      car_arrival  <= 1'b0;
    end else begin
      if (loop_s == car_detected) begin
        db_cnt <= '0;
      end else if (db_flip) begin
        db_cnt       <= '0;
        car_detected <= loop_s;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
      car_arrival <= db_flip && loop_s;
    end
  end

  // A clear in the same cycle as an arrival pulse leaves the count at 1:
  // the clear wins over the old value but the new arrival is still counted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      arrivals <= '0;
    end else if (clear_arrivals) begin
      arrivals <= CNT_W'(car_arrival);
    end else if (car_arrival && (arrivals != {CNT_W{1'b1}})) begin
      arrivals <= arrivals + CNT_W'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Emergency FSM
  // --------------------------------------------------------------------------
  // One shared counter serves CONFIRM (samples seen), HOLD and COOLDOWN
  // (cycles spent); every entry into a counting state reloads it.
  emg_state_t      state, state_next;
  logic [EC_W-1:0] emg_cnt, cnt_next;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      emg_cnt   <= '0;
      emergency <= 1'b0;
    end else begin
      state     <= state_next;
      emg_cnt   <= cnt_next;
      emergency <= (state_next == S_ACTIVE) || (state_next == S_HOLD);
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = emg_cnt;
    case (state)
      S_IDLE: begin
        if (siren_s) begin
          if (EMG_CONFIRM == 1) begin
            state_next = S_ACTIVE;
          end else begin
            state_next = S_CONFIRM;
            cnt_next   = EC_W'(1);
          end
        end
      end
      S_CONFIRM: begin
        if (!siren_s) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else if (emg_cnt == CONF_LAST) begin
          state_next = S_ACTIVE;
          cnt_next   = '0;
        end else begin
          cnt_next = emg_cnt + EC_W'(1);
        end
      end
      S_ACTIVE: begin
        if (!siren_s) begin
          state_next = S_HOLD;
          cnt_next   = '0;
        end
      end
      S_HOLD: begin
        if (siren_s) begin
          state_next = S_ACTIVE;
          cnt_next   = '0;
        end else if (emg_cnt == HOLD_LAST) begin
          state_next = S_COOLDOWN;
          cnt_next   = '0;
        end else begin
          cnt_next = emg_cnt + EC_W'(1);
        end
      end
      S_COOLDOWN: begin
        // siren_s is deliberately ignored here
        if (emg_cnt == COOL_LAST) begin
          state_next = S_IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = emg_cnt + EC_W'(1);
        end
      end
      default: begin
        state_next = S_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign emg_state = state;

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// Bench for traffic_sensor_conditioner (default parameters).
// A behavioural model tracks the expected outputs every cycle; directed
// sequences add literal expectations at hand-computed cycle offsets.
// Inputs change at negedge+1, the compare process samples at negedge+2.

module tb_traffic_sensor_conditioner;

  localparam int DEB   = 4;
  localparam int CONF  = 3;
  localparam int HOLD  = 8;
  localparam int COOL  = 4;
  localparam int CNT_W = 4;
  localparam int MAXA  = (1 << CNT_W) - 1;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic loop_raw = 1'b0;
  logic siren_raw = 1'b0;
  logic clear_arrivals = 1'b0;

  logic             car_detected;
  logic             car_arrival;
  logic             emergency;
  logic [CNT_W-1:0] arrivals;
  logic [2:0]       emg_state;

  always #5 clk = ~clk;

  traffic_sensor_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .EMG_CONFIRM(CONF),
    .EMG_HOLD(HOLD),
    .EMG_COOLDOWN(COOL),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .loop_raw(loop_raw),
    .siren_raw(siren_raw),
    .clear_arrivals(clear_arrivals),
    .car_detected(car_detected),
    .car_arrival(car_arrival),
    .emergency(emergency),
    .arrivals(arrivals),
    .emg_state(emg_state)
  );

  // ---------------- scoreboard counters ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Synchroniser = two-sample delay line. Debounce: car_detected takes the
  // synced value once the last DEB synced samples all disagree with it.
  // Emergency: phase number with countdown timers.
  logic lpipe[2] = '{1'b0, 1'b0};
  logic spipe[2] = '{1'b0, 1'b0};
  logic lhist[$];
  logic m_car = 1'b0;
  logic m_arrival = 1'b0;
  int   m_arrivals = 0;
  int   m_phase = 0;
  int   m_streak = 0;
  int   m_left = 0;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      lpipe = '{1'b0, 1'b0};
      spipe = '{1'b0, 1'b0};
      lhist.delete();
      m_car = 1'b0;
      m_arrival = 1'b0;
      m_arrivals = 0;
      m_phase = 0;
      m_streak = 0;
      m_left = 0;
    end else begin
      logic ls, ss;
      bit   all_differ;
      ls = lpipe[1];
      ss = spipe[1];

      // arrivals uses last cycle's pulse
      if (clear_arrivals) m_arrivals = m_arrival ? 1 : 0;
      else if (m_arrival && m_arrivals < MAXA) m_arrivals = m_arrivals + 1;

      // debounce
      lhist.push_back(ls);
      if (lhist.size() > DEB) void'(lhist.pop_front());
      all_differ = (lhist.size() == DEB);
      foreach (lhist[i]) if (lhist[i] == m_car) all_differ = 0;
      m_arrival = 1'b0;
      if (all_differ) begin
        m_car = ~m_car;
        m_arrival = m_car;
        lhist.delete();
      end

      // emergency
      case (m_phase)
        0: if (ss) begin m_streak = 1; m_phase = (CONF == 1) ? 2 : 1; end
        1: if (!ss) m_phase = 0;
           else begin m_streak++; if (m_streak >= CONF) m_phase = 2; end
        2: if (!ss) begin m_phase = 3; m_left = HOLD; end
        3: if (ss) m_phase = 2;
           else begin m_left--; if (m_left == 0) begin m_phase = 4; m_left = COOL; end end
        default: begin m_left--; if (m_left == 0) m_phase = 0; end
      endcase

      lpipe[1] = lpipe[0]; lpipe[0] = loop_raw;
      spipe[1] = spipe[0]; spipe[0] = siren_raw;
    end
  end

  // ---------------- per-cycle compare ----------------
  always begin
    @(negedge clk);
    #2;
    chk("cyc_car_detected", 32'(car_detected), 32'(m_car));
    chk("cyc_car_arrival", 32'(car_arrival), 32'(m_arrival));
    chk("cyc_arrivals", 32'(arrivals), 32'(m_arrivals));
    chk("cyc_emg_state", 32'(emg_state), 32'(m_phase));
    chk("cyc_emergency", 32'(emergency), 32'((m_phase == 2) || (m_phase == 3)));
  end

  // ---------------- driver tasks ----------------
  // tick(n): advance n clock edges, land at negedge+1
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_car"}, 32'(car_detected), 0);
    chk({name, "_arr"}, 32'(car_arrival), 0);
    chk({name, "_emg"}, 32'(emergency), 0);
    chk({name, "_cnt"}, 32'(arrivals), 0);
    chk({name, "_st"}, 32'(emg_state), 0);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    // reset with raw inputs toggling
    for (int i = 0; i < 6; i++) begin
      tick(1);
      loop_raw = ~loop_raw;
      siren_raw = ~siren_raw;
    end
    chk_all_zero("in_reset");
    loop_raw = 1'b0;
    siren_raw = 1'b0;
    rst = 1'b1;
    tick(20);
    chk_all_zero("after_reset");

    // clean car: rise seen 6 edges later, pulse, count
    loop_raw = 1'b1;
    tick(5);
    chk("clean_rise_e5", 32'(car_detected), 0);
    tick(1);
    chk("clean_rise_e6", 32'(car_detected), 1);
    chk("clean_pulse", 32'(car_arrival), 1);
    tick(1);
    chk("clean_pulse_end", 32'(car_arrival), 0);
    chk("clean_count", 32'(arrivals), 1);
    loop_raw = 1'b0;
    tick(5);
    chk("clean_fall_e5", 32'(car_detected), 1);
    tick(1);
    chk("clean_fall_e6", 32'(car_detected), 0);
    chk("clean_fall_nopulse", 32'(car_arrival), 0);
    tick(2);
    chk("clean_fall_count", 32'(arrivals), 1);

    // bounce: high 3, low 1, high 10
    loop_raw = 1'b1;
    tick(3);
    loop_raw = 1'b0;
    tick(1);
    loop_raw = 1'b1;
    tick(5);
    chk("bounce_e5", 32'(car_detected), 0);
    tick(1);
    chk("bounce_e6", 32'(car_detected), 1);
    tick(4);
    chk("bounce_count", 32'(arrivals), 2);
    loop_raw = 1'b0;
    tick(8);

    // saturation: 20 arrivals on top of 2
    for (int i = 0; i < 20; i++) begin
      loop_raw = 1'b1;
      tick(8);
      loop_raw = 1'b0;
      tick(8);
    end
    chk("saturated", 32'(arrivals), MAXA);

    // clear coincident with arrival pulse
    loop_raw = 1'b1;
    tick(6);
    chk("clr_pulse", 32'(car_arrival), 1);
    clear_arrivals = 1'b1;
    tick(1);
    clear_arrivals = 1'b0;
    chk("clr_with_arrival", 32'(arrivals), 1);
    loop_raw = 1'b0;
    tick(8);

    // siren glitch: 2 cycles high, reaches CONFIRM only
    siren_raw = 1'b1;
    tick(2);
    siren_raw = 1'b0;
    tick(1);
    chk("glitch_e3_state", 32'(emg_state), 1);
    tick(1);
    chk("glitch_e4_state", 32'(emg_state), 1);
    tick(1);
    chk("glitch_e5_state", 32'(emg_state), 0);
    chk("glitch_emg", 32'(emergency), 0);
    tick(5);

    // full emergency: siren high 10 edges, pulse during cooldown
    siren_raw = 1'b1;
    tick(4);
    chk("full_e4", 32'(emergency), 0);
    tick(1);
    chk("full_e5", 32'(emergency), 1);
    chk("full_e5_state", 32'(emg_state), 2);
    tick(5);
    siren_raw = 1'b0;      // low from edge 11
    tick(9);               // after edge 19
    siren_raw = 1'b1;      // high for edges 20..22
    tick(1);
    chk("hold_last_emg", 32'(emergency), 1);
    chk("hold_last_state", 32'(emg_state), 3);
    tick(1);
    chk("cool_emg", 32'(emergency), 0);
    chk("cool_state", 32'(emg_state), 4);
    tick(1);
    siren_raw = 1'b0;
    tick(3);
    chk("cool_ignored_state", 32'(emg_state), 0);
    tick(3);
    chk("cool_ignored_later", 32'(emg_state), 0);
    chk("cool_ignored_emg", 32'(emergency), 0);

    // siren held through cooldown
    siren_raw = 1'b1;      // high edges 1..8
    tick(8);
    siren_raw = 1'b0;      // low edges 9..17
    tick(9);
    siren_raw = 1'b1;      // high from edge 18
    tick(5);
    chk("held_e22_state", 32'(emg_state), 4);
    tick(1);
    chk("held_e23_state", 32'(emg_state), 0);
    tick(1);
    chk("held_e24_state", 32'(emg_state), 1);
    tick(1);
    chk("held_e25_state", 32'(emg_state), 1);
    tick(1);
    chk("held_e26_state", 32'(emg_state), 2);
    chk("held_e26_emg", 32'(emergency), 1);

    // HOLD re-trigger: low edges 27..29, high from 30
    siren_raw = 1'b0;
    tick(3);
    siren_raw = 1'b1;
    tick(1);
    chk("retrig_e30_state", 32'(emg_state), 3);
    chk("retrig_e30_emg", 32'(emergency), 1);
    tick(2);
    chk("retrig_e32_state", 32'(emg_state), 2);
    chk("retrig_e32_emg", 32'(emergency), 1);
    tick(3);

    // reset during ACTIVE
    rst = 1'b0;
    #1;
    chk("midrst_emg", 32'(emergency), 0);
    chk("midrst_state", 32'(emg_state), 0);
    chk("midrst_cnt", 32'(arrivals), 0);
    tick(2);
    siren_raw = 1'b0;
    rst = 1'b1;
    tick(10);
    chk_all_zero("final");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
